// File: rtl/tb_dmem_pkg.sv
// Shared types for the bench-side data-memory initiator: access sizes, FSM states, latency bound.
// VERIFY exists only when TB_DMEM_INIT_READBACK_EN is defined.
package tb_dmem_pkg;

    localparam int MAX_READ_LATENCY = 4;

    typedef enum logic [1:0] {
        SIZE_BYTE    = 2'd0,
        SIZE_HALF    = 2'd1,
        SIZE_WORD    = 2'd2,
        SIZE_ILLEGAL = 2'd3
    } size_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
`ifdef TB_DMEM_INIT_READBACK_EN
        ST_VERIFY,
`endif
        ST_RESP
    } state_e;

endpackage

// File: rtl/tb_dmem_initiator_if.sv
// Command/response handshake plus darkriscv data-port strobes between a bench sequencer, the initiator and the memory model.
// slave = initiator view, master = sequencer/memory view.
interface tb_dmem_initiator_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;

    logic                  rsp_valid;
    logic [31:0]           rsp_rdata;
    logic                  rsp_error;

    logic [ADDR_WIDTH-1:0] daddr;
    logic                  rd;
    logic                  wr;
    logic [3:0]            be;
    logic [31:0]           datao;
    logic [31:0]           datai;

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, datai,
        output req_ready, rsp_valid, rsp_rdata, rsp_error, daddr, rd, wr, be, datao
    );

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, datai,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error, daddr, rd, wr, be, datao
    );

endinterface

// File: rtl/tb_dmem_lane.sv
// Byte-lane helper: be/datao generation, alignment check, load lane extract with sign/zero extension.
// Purely combinational, zero latency, no flow control.
module tb_dmem_lane
    import tb_dmem_pkg::*;
(
    input  size_e       size,
    input  logic [1:0]  addr_lo,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic        misalign,
    output logic [31:0] rdata_ext
);

    logic [31:0] lane_sh;

    always_comb begin
        lane_sh   = rdata >> {addr_lo, 3'b000};
        be        = 4'b0000;
        wdata_rep = wdata;
        misalign  = 1'b0;
        rdata_ext = 32'h0;
        case (size)
            SIZE_BYTE: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = {{24{~is_unsigned & lane_sh[7]}}, lane_sh[7:0]};
            end
            SIZE_HALF: begin
                misalign  = addr_lo[0];
                be        = 4'b0011 << addr_lo;
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = {{16{~is_unsigned & lane_sh[15]}}, lane_sh[15:0]};
            end
            SIZE_WORD: begin
                misalign  = |addr_lo;
                be        = 4'b1111;
                rdata_ext = lane_sh;
            end
            default: misalign = 1'b1;
        endcase
    end

endmodule

// File: rtl/tb_dmem_initiator.sv
// Single load/store initiator for the darkriscv data port; optional store readback via TB_DMEM_INIT_READBACK_EN.
// Latency: error T+1, store T+2 (T+3+READ_LATENCY with readback), load T+2+READ_LATENCY; req_ready only in IDLE, no rsp backpressure.
module tb_dmem_initiator
    import tb_dmem_pkg::*;
#(
    parameter int READ_LATENCY = 1,
    parameter int ADDR_WIDTH   = 32
) (
    input  logic               clock,
    input  logic               reset,
    tb_dmem_initiator_if.slave bus
);

    localparam logic [2:0] WAIT_LAST = 3'(READ_LATENCY - 1);

    state_e                state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic                  cmd_write_q, cmd_write_d;
    size_e                 cmd_size_q, cmd_size_d;
    logic                  cmd_uns_q, cmd_uns_d;
    logic [1:0]            cmd_alo_q, cmd_alo_d;
    logic                  rd_q, rd_d, wr_q, wr_d;
    logic [3:0]            be_q, be_d;
    logic [ADDR_WIDTH-1:0] daddr_q, daddr_d;
    logic [31:0]           datao_q, datao_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_error_q, rsp_error_d;
    logic [31:0]           rsp_rdata_q, rsp_rdata_d;

    // Lane helper sees the live request while idle and the held command afterwards.
    logic        idle;
    size_e       lane_size;
    logic [1:0]  lane_alo;
    logic        lane_uns;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata, lane_rdata;
    logic        lane_misalign;

    assign idle      = (state_q == ST_IDLE);
    assign lane_size = idle ? size_e'(bus.req_size) : cmd_size_q;
    assign lane_alo  = idle ? bus.req_addr[1:0]     : cmd_alo_q;
    assign lane_uns  = idle ? bus.req_unsigned      : cmd_uns_q;

    tb_dmem_lane u_lane (
        .size        (lane_size),
        .addr_lo     (lane_alo),
        .is_unsigned (lane_uns),
        .wdata       (bus.req_wdata),
        .rdata       (bus.datai),
        .be          (lane_be),
        .wdata_rep   (lane_wdata),
        .misalign    (lane_misalign),
        .rdata_ext   (lane_rdata)
    );

`ifdef TB_DMEM_INIT_READBACK_EN
    localparam logic [2:0] VERIFY_LAST = 3'(READ_LATENCY);
    logic [31:0] lane_mask;
    assign lane_mask = {{8{lane_be[3]}}, {8{lane_be[2]}}, {8{lane_be[1]}}, {8{lane_be[0]}}};
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cmd_write_d = cmd_write_q;
        cmd_size_d  = cmd_size_q;
        cmd_uns_d   = cmd_uns_q;
        cmd_alo_d   = cmd_alo_q;
        rd_d        = 1'b0;
        wr_d        = 1'b0;
        be_d        = 4'b0000;
        daddr_d     = daddr_q;
        datao_d     = datao_q;
        rsp_valid_d = 1'b0;
        rsp_error_d = 1'b0;
        rsp_rdata_d = 32'h0;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    cmd_write_d = bus.req_write;
                    cmd_size_d  = size_e'(bus.req_size);
                    cmd_uns_d   = bus.req_unsigned;
                    cmd_alo_d   = bus.req_addr[1:0];
                    if (lane_misalign) begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_error_d = 1'b1;
                    end else begin
                        state_d = ST_ISSUE;
                        rd_d    = ~bus.req_write;
                        wr_d    = bus.req_write;
                        be_d    = lane_be;
                        daddr_d = {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
                        datao_d = lane_wdata;
                    end
                end
            end
            ST_ISSUE: begin
                cnt_d = 3'd0;
                if (cmd_write_q) begin
`ifdef TB_DMEM_INIT_READBACK_EN
                    state_d = ST_VERIFY;
                    rd_d    = 1'b1;
                    be_d    = be_q;
`else
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
`endif
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = lane_rdata;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
`ifdef TB_DMEM_INIT_READBACK_EN
            // The readback rd cycle is count 0, so data arrives READ_LATENCY counts later.
            ST_VERIFY: begin
                if (cnt_q == VERIFY_LAST) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_error_d = |((bus.datai ^ datao_q) & lane_mask);
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
`endif
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 3'd0;
            cmd_write_q <= 1'b0;
            cmd_size_q  <= SIZE_BYTE;
            cmd_uns_q   <= 1'b0;
            cmd_alo_q   <= 2'b00;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            be_q        <= 4'b0000;
            daddr_q     <= '0;
            datao_q     <= 32'h0;
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_write_q <= cmd_write_d;
            cmd_size_q  <= cmd_size_d;
            cmd_uns_q   <= cmd_uns_d;
            cmd_alo_q   <= cmd_alo_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            be_q        <= be_d;
            daddr_q     <= daddr_d;
            datao_q     <= datao_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_error_q <= rsp_error_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign bus.req_ready = idle;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_error = rsp_error_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rd        = rd_q;
    assign bus.wr        = wr_q;
    assign bus.be        = be_q;
    assign bus.daddr     = daddr_q;
    assign bus.datao     = datao_q;

endmodule

// File: tb/tb_tb_dmem_initiator.sv
// Directed bench: two initiators (READ_LATENCY 1 and 3) on small byte-lane memory models.
// Expected values are hand-computed in the vector table.
module tb_tb_dmem_initiator;

`ifdef TB_DMEM_INIT_READBACK_EN
    localparam int RB = 1;
`else
    localparam int RB = 0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        sel = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        corrupt = 1'b0;

    tb_dmem_initiator_if #(.ADDR_WIDTH(32)) b1 ();
    tb_dmem_initiator_if #(.ADDR_WIDTH(32)) b3 ();

    tb_dmem_initiator #(.READ_LATENCY(1), .ADDR_WIDTH(32)) u_dut1 (.clock(clk), .reset(reset), .bus(b1));
    tb_dmem_initiator #(.READ_LATENCY(3), .ADDR_WIDTH(32)) u_dut3 (.clock(clk), .reset(reset), .bus(b3));

    assign b1.req_valid = req_valid & ~sel;
    assign b3.req_valid = req_valid & sel;
    assign b1.req_write = req_write;      assign b3.req_write = req_write;
    assign b1.req_size = req_size;        assign b3.req_size = req_size;
    assign b1.req_unsigned = req_unsigned; assign b3.req_unsigned = req_unsigned;
    assign b1.req_addr = req_addr;        assign b3.req_addr = req_addr;
    assign b1.req_wdata = req_wdata;      assign b3.req_wdata = req_wdata;

    // Memory models: byte-lane writes, read data returned READ_LATENCY cycles after the rd cycle.
    logic [31:0] mem1 [64];
    logic [31:0] mem3 [64];
    logic [31:0] p1, q0, q1, q2;
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (b1.wr && b1.be[i]) mem1[b1.daddr[7:2]][8*i +: 8] <= b1.datao[8*i +: 8];
            if (b3.wr && b3.be[i]) mem3[b3.daddr[7:2]][8*i +: 8] <= b3.datao[8*i +: 8];
        end
        p1 <= b1.rd ? mem1[b1.daddr[7:2]] : 32'h0;
        q0 <= b3.rd ? mem3[b3.daddr[7:2]] : 32'h0;
        q1 <= q0;
        q2 <= q1;
    end
    assign b1.datai = p1 ^ (corrupt ? 32'h00FF_0000 : 32'h0);
    assign b3.datai = q2;

    logic        o_ready, o_rsp_valid, o_rsp_error, o_rd, o_wr;
    logic [31:0] o_rsp_rdata, o_daddr, o_datao;
    logic [3:0]  o_be;
    assign o_ready     = sel ? b3.req_ready : b1.req_ready;
    assign o_rsp_valid = sel ? b3.rsp_valid : b1.rsp_valid;
    assign o_rsp_error = sel ? b3.rsp_error : b1.rsp_error;
    assign o_rsp_rdata = sel ? b3.rsp_rdata : b1.rsp_rdata;
    assign o_rd        = sel ? b3.rd : b1.rd;
    assign o_wr        = sel ? b3.wr : b1.wr;
    assign o_be        = sel ? b3.be : b1.be;
    assign o_daddr     = sel ? b3.daddr : b1.daddr;
    assign o_datao     = sel ? b3.datao : b1.datao;

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Drive one command, follow it to its response pulse, record strobes seen on the way.
    task automatic xact(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] wd,
                        output int lat, output int nstb, output logic [1:0] kind,
                        output logic [3:0] sbe, output logic [31:0] sdat, output logic [31:0] sadr,
                        output logic [31:0] rdat, output logic err);
        req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1; nstb = 0; kind = 2'b00; sbe = 4'h0; sdat = 32'h0; sadr = 32'h0;
        while (!o_rsp_valid && lat < 20) begin
            if (o_rd || o_wr) begin
                if (nstb == 0) begin
                    kind = {o_rd, o_wr}; sbe = o_be; sdat = o_datao; sadr = o_daddr;
                end
                nstb++;
            end
            @(posedge clk); #1;
            lat++;
        end
        if (o_rd || o_wr) nstb++;
        rdat = o_rsp_rdata;
        err  = o_rsp_error;
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic        u;
        logic [31:0] a, wd;
        int          lat, nstb;
        logic [3:0]  be;
        logic [31:0] dat, rdat;
        logic        err;
    } vec_t;

    function automatic vec_t mk(input logic w, input logic [1:0] sz, input logic u,
                                input logic [31:0] a, input logic [31:0] wd, input int lat,
                                input int nstb, input logic [3:0] be, input logic [31:0] dat,
                                input logic [31:0] rdat, input logic err);
        vec_t v;
        v.w = w; v.sz = sz; v.u = u; v.a = a; v.wd = wd; v.lat = lat; v.nstb = nstb;
        v.be = be; v.dat = dat; v.rdat = rdat; v.err = err;
        return v;
    endfunction

    localparam int SL1 = 2 + RB * 2;   // store latency at READ_LATENCY 1
    localparam int SL3 = 2 + RB * 4;   // store latency at READ_LATENCY 3
    localparam int SS  = 1 + RB;       // strobe cycles per store

    vec_t vt [14];

    initial begin
        int lat, nstb, n;
        logic [1:0] kind;
        logic [3:0] sbe;
        logic [31:0] sdat, sadr, rdat;
        logic err;

        vt[0]  = mk(1, 2, 0, 32'h100, 32'hDEADBEEF, SL1, SS, 4'hF, 32'hDEADBEEF, 32'h0, 0);
        vt[1]  = mk(0, 2, 0, 32'h100, 32'h0, 3, 1, 4'hF, 32'h0, 32'hDEADBEEF, 0);
        vt[2]  = mk(1, 0, 0, 32'h103, 32'h80, SL1, SS, 4'h8, 32'h80808080, 32'h0, 0);
        vt[3]  = mk(0, 0, 0, 32'h103, 32'h0, 3, 1, 4'h8, 32'h0, 32'hFFFFFF80, 0);
        vt[4]  = mk(0, 0, 1, 32'h103, 32'h0, 3, 1, 4'h8, 32'h0, 32'h00000080, 0);
        vt[5]  = mk(1, 1, 0, 32'h102, 32'h55558001, SL1, SS, 4'hC, 32'h80018001, 32'h0, 0);
        vt[6]  = mk(0, 1, 0, 32'h102, 32'h0, 3, 1, 4'hC, 32'h0, 32'hFFFF8001, 0);
        vt[7]  = mk(0, 1, 1, 32'h100, 32'h0, 3, 1, 4'h3, 32'h0, 32'h0000BEEF, 0);
        vt[8]  = mk(0, 0, 0, 32'h101, 32'h0, 3, 1, 4'h2, 32'h0, 32'hFFFFFFBE, 0);
        vt[9]  = mk(0, 2, 0, 32'h101, 32'h0, 1, 0, 4'h0, 32'h0, 32'h0, 1);
        vt[10] = mk(1, 3, 0, 32'h100, 32'h12345678, 1, 0, 4'h0, 32'h0, 32'h0, 1);
        vt[11] = mk(1, 1, 0, 32'h103, 32'h1234, 1, 0, 4'h0, 32'h0, 32'h0, 1);
        vt[12] = mk(1, 2, 0, 32'h104, 32'h01234567, SL1, SS, 4'hF, 32'h01234567, 32'h0, 0);
        vt[13] = mk(0, 2, 0, 32'h104, 32'h0, 3, 1, 4'hF, 32'h0, 32'h01234567, 0);

        // Reset state of both instances while reset is held.
        #1;
        for (int s = 0; s < 2; s++) begin
            sel = s[0]; #1;
            check($sformatf("rst%0d_ready", s), {31'h0, o_ready}, 32'h1);
            check($sformatf("rst%0d_rsp", s), {29'h0, o_rsp_valid, o_rsp_error, o_rd}, 32'h0);
            check($sformatf("rst%0d_wr_be", s), {27'h0, o_wr, o_be}, 32'h0);
            check($sformatf("rst%0d_daddr", s), o_daddr, 32'h0);
            check($sformatf("rst%0d_datao", s), o_datao, 32'h0);
            check($sformatf("rst%0d_rdata", s), o_rsp_rdata, 32'h0);
        end
        sel = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 14; i++) begin
            xact(vt[i].w, vt[i].sz, vt[i].u, vt[i].a, vt[i].wd, lat, nstb, kind, sbe, sdat, sadr, rdat, err);
            check($sformatf("v%0d_lat", i), lat, vt[i].lat);
            check($sformatf("v%0d_nstb", i), nstb, vt[i].nstb);
            check($sformatf("v%0d_err", i), {31'h0, err}, {31'h0, vt[i].err});
            check($sformatf("v%0d_rdata", i), rdat, vt[i].rdat);
            if (vt[i].nstb > 0) begin
                check($sformatf("v%0d_kind", i), {30'h0, kind}, vt[i].w ? 32'h1 : 32'h2);
                check($sformatf("v%0d_be", i), {28'h0, sbe}, {28'h0, vt[i].be});
                check($sformatf("v%0d_daddr", i), sadr, vt[i].a & 32'hFFFF_FFFC);
                if (vt[i].w) check($sformatf("v%0d_datao", i), sdat, vt[i].dat);
            end
        end

`ifdef TB_DMEM_INIT_READBACK_EN
        corrupt = 1'b1;
        xact(1, 2, 0, 32'h108, 32'hCAFEF00D, lat, nstb, kind, sbe, sdat, sadr, rdat, err);
        check("rb_bad_lat", lat, 4);
        check("rb_bad_err", {31'h0, err}, 32'h1);
        xact(1, 0, 0, 32'h10C, 32'h5A, lat, nstb, kind, sbe, sdat, sadr, rdat, err);
        check("rb_lane0_err", {31'h0, err}, 32'h0);
        corrupt = 1'b0;
`endif

        // Reset while the READ_LATENCY 3 instance is waiting on a load.
        sel = 1'b1; #1;
        req_write = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h40; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("mid_rd_issue", {31'h0, o_rd}, 32'h1);
        @(posedge clk); #1;
        check("mid_daddr", o_daddr, 32'h40);
        reset = 1'b1; #1;
        check("mid_rst_rd", {31'h0, o_rd}, 32'h0);
        check("mid_rst_rsp", {31'h0, o_rsp_valid}, 32'h0);
        check("mid_rst_ready", {31'h0, o_ready}, 32'h1);
        check("mid_rst_daddr", o_daddr, 32'h0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        n = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (o_rsp_valid) n++;
        end
        check("mid_no_rsp", n, 0);
        xact(1, 2, 0, 32'h20, 32'h12345678, lat, nstb, kind, sbe, sdat, sadr, rdat, err);
        check("post_st_lat", lat, SL3);
        check("post_st_err", {31'h0, err}, 32'h0);
        xact(0, 2, 0, 32'h20, 32'h0, lat, nstb, kind, sbe, sdat, sadr, rdat, err);
        check("post_ld_lat", lat, 5);
        check("post_ld_rdata", rdat, 32'h12345678);
        xact(0, 1, 0, 32'h21, 32'h0, lat, nstb, kind, sbe, sdat, sadr, rdat, err);
        check("post_mis_lat", lat, 1);
        check("post_mis_err", {31'h0, err}, 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/tb_dmem_initiator.md
Name: tb_dmem_initiator

Overview:
- Bench-side data-memory initiator for the darkriscv memory model.
- Converts single load/store commands from a bench sequencer (valid/ready) into data-port strobes: daddr, rd, wr, be, datao.
- Captures datai after a fixed read latency, aligns and sign/zero-extends it, and returns a one-cycle response.
- Lets the memory model be exercised without the core attached.

Parameters:
- READ_LATENCY, 1, cycles from the rd strobe cycle until datai is valid (1..4).
- ADDR_WIDTH, 32, width of req_addr and daddr.

Ports:
- clock  input  1  single clock; all state changes on its rising edge
- reset  input  1  asynchronous, active-high reset
- req_valid  input  1  command present
- req_ready  output  1  command accepted when high together with req_valid
- req_write  input  1  1 = store, 0 = load
- req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = illegal
- req_unsigned  input  1  load zero-extend (1) or sign-extend (0)
- req_addr  input  ADDR_WIDTH  byte address
- req_wdata  input  32  store data, LSB-justified
- rsp_valid  output  1  one-cycle response pulse
- rsp_rdata  output  32  extended load data; 0 for stores and errors
- rsp_error  output  1  misaligned/illegal access (or readback mismatch, see Optional Feature)
- daddr  output  ADDR_WIDTH  word-aligned address (req_addr with bits 1:0 cleared)
- rd  output  1  read strobe
- wr  output  1  write strobe
- be  output  4  byte-lane mask
- datao  output  32  lane-replicated store data
- datai  input  32  read data from memory

Behaviour:
- Reset: asynchronous. Immediately forces state IDLE, req_ready=1, rsp_valid=0, rsp_error=0, rsp_rdata=0, rd=0, wr=0, be=0, daddr=0, datao=0.
  - Any in-flight transaction is dropped; no response is ever issued for it.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE
  - req_ready=1 only in IDLE.
  - On accept (edge T), the command is registered.
  - Legal command -> ISSUE.
  - Misaligned or illegal command -> RESP with error.
- Misalignment rules:
  - half with addr[0]=1 is misaligned.
  - word with addr[1:0]!=0 is misaligned.
  - size=3 is illegal.
- ISSUE (cycle T+1), exactly one cycle:
  - rd or wr=1.
  - be: byte -> 1<<addr[1:0]; half -> 4'b0011<<addr[1:0]; word -> 4'b1111.
  - datao: byte -> {4{wdata[7:0]}}; half -> {2{wdata[15:0]}}; word -> wdata.
  - Store -> RESP. Load -> WAIT.
- WAIT:
  - Counts READ_LATENCY-1 extra cycles.
  - datai is sampled at the end of cycle T+1+READ_LATENCY.
  - The selected lane (addr[1:0]) is extracted and extended.
  - -> RESP.
- RESP (one cycle):
  - rsp_valid=1 with rsp_rdata and rsp_error.
  - -> IDLE.
  - A new command can be accepted in the cycle after RESP.
- Latency:
  - store: rsp_valid at T+2.
  - load: rsp_valid at T+2+READ_LATENCY.
  - error: rsp_valid at T+1, with no rd/wr strobe.
- Outside ISSUE: rd=wr=0 and be=0. daddr/datao hold their last value.
- No response back-pressure. rsp_valid is a pulse the bench must sample.
- req_* inputs are ignored outside IDLE.

Optional Feature:
- Macro: TB_DMEM_INIT_READBACK_EN.
- Defined:
  - After a legal store's wr cycle, the block issues one rd cycle to the same daddr.
  - It waits READ_LATENCY cycles and compares datai against datao on the be lanes only.
  - Uses extra state VERIFY, entered from ISSUE on a store and left to RESP.
  - Mismatch -> rsp_error=1.
  - Store rsp_valid moves to T+3+READ_LATENCY.
- Undefined:
  - No VERIFY state is generated.
  - Store latency is T+2.
  - rsp_error reflects alignment only.

Decomposition:
- Package tb_dmem_pkg holds:
  - size enum (SIZE_BYTE, SIZE_HALF, SIZE_WORD, SIZE_ILLEGAL);
  - FSM state enum;
  - constant MAX_READ_LATENCY=4.
- Sub-module tb_dmem_lane: purely combinational.
  - Outputs: be generation, datao replication, misalignment flag.
  - Load lane extraction and sign/zero extension.
  - Instantiated once, shared by issue and capture paths.

Test Plan:
- Word store then load:
  - Store addr=0x100, data=0xDEADBEEF -> wr at T+1, be=4'b1111, rsp at T+2 with error=0.
  - Load 0x100 -> rsp_rdata=0xDEADBEEF at T+3 (READ_LATENCY=1).
- Byte lanes:
  - Store byte 0x80 at 0x103 -> be=4'b1000, datao=0x80808080.
  - Signed byte load 0x103 -> 0xFFFFFF80; unsigned -> 0x00000080.
- Half:
  - Store 0x8001 at 0x102 -> be=4'b1100.
  - Signed half load -> 0xFFFF8001.
- Misaligned and illegal:
  - Word at 0x101 -> rsp_error=1 at T+1, rd=wr=0 throughout.
  - size=3 -> same.
- Reset mid-load (READ_LATENCY=3):
  - Assert reset during WAIT -> rd=0, rsp_valid=0 immediately; no response after release; next command is handled normally.
- READBACK_EN:
  - Force a memory-side corruption on lane 2 -> store rsp_error=1 at T+3+READ_LATENCY.
  - Clean store -> error=0.
